// File: rtl/ddr2_wr_burst_sequencer_0.sv
// DDR2 write-burst sequencer: enforces WRITE command spacing, delays accepted commands by the
// write latency and generates FIFO read, write-enable and DQS controls for the write datapath.
//   state | meaning
//   IDLE  | DQS not driven, no burst in progress
//   PRE   | DQS preamble cycle, first FIFO read
//   DATA  | write data cycles (bursts may chain without a new preamble)
module ddr2_wr_burst_sequencer_0 #(
    parameter int WR_LAT    = 3,
    parameter int BURST_LEN = 4
) (
    input  logic       clk_i,
    input  logic       reset0_i,
    input  logic       wr_cmd_i,
    output logic       wdf_rden_o,
    output logic       ctrl_wren_o,
    output logic       ctrl_dqs_rst_o,
    output logic       ctrl_dqs_en_o,
    output logic       wr_busy_o,
    output logic       wr_overlap_err_o,
    output logic [7:0] burst_cnt_o
);

    localparam int             NB       = BURST_LEN / 2;
    localparam logic [3:0]     NB_GAP   = 4'(NB);
    localparam logic [2:0]     NB_M1    = 3'(NB - 1);
    localparam logic [4:0]     BUSY_LEN = 5'(WR_LAT + NB - 1);

    typedef enum logic [1:0] {IDLE, PRE, DATA} state_t;

    state_t            state_q, state_d;
    logic [2:0]        bc_q, bc_d;
    logic [3:0]        gap_q, gap_d;
    logic [WR_LAT-2:0] dl_q, dl_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [4:0]        busy_cnt_q, busy_cnt_d;
    logic              busy_q, busy_d;
    logic              drop_q, drop_d;
    logic              err_q, err_d;
    logic              rden_q, rden_d;
    logic              wren_q, wren_d;
    logic              dqs_en_q, dqs_en_d;
    logic              dqs_rst_q, dqs_rst_d;
    logic              accept;
    logic              start;

    // Command acceptance, latency delay line and bookkeeping
    always_comb begin
        accept     = wr_cmd_i && (gap_q >= NB_GAP);
        gap_d      = gap_q;
        if (accept) begin
            gap_d = 4'd1;
        end else if (gap_q < NB_GAP) begin
            gap_d = gap_q + 4'd1;
        end
        dl_d       = dl_q;
        dl_d[0]    = accept;
        for (int i = 1; i < WR_LAT - 1; i++) begin
            dl_d[i] = dl_q[i-1];
        end
        start      = dl_q[WR_LAT-2];
        cnt_d      = accept ? cnt_q + 8'd1 : cnt_q;
        drop_d     = wr_cmd_i && !accept;
        err_d      = err_q || drop_q;
        busy_d     = accept || (busy_cnt_q != 5'd0);
        busy_cnt_d = busy_cnt_q;
        if (accept) begin
            busy_cnt_d = BUSY_LEN;
        end else if (busy_cnt_q != 5'd0) begin
            busy_cnt_d = busy_cnt_q - 5'd1;
        end
    end

    // DQS / data FSM; outputs are computed one cycle ahead and registered
    always_comb begin
        state_d   = state_q;
        bc_d      = bc_q;
        rden_d    = 1'b0;
        wren_d    = rden_q;
        dqs_rst_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = PRE;
                    rden_d    = 1'b1;
                    dqs_rst_d = 1'b1;
                    bc_d      = NB_M1;
                end
            end
            PRE, DATA: begin
                if (start) begin
                    // DQS is still driven, so the new burst needs no preamble pulse
                    rden_d  = 1'b1;
                    bc_d    = NB_M1;
                    state_d = rden_q ? DATA : PRE;
                end else if (bc_q != 3'd0) begin
                    rden_d  = 1'b1;
                    bc_d    = bc_q - 3'd1;
                    state_d = DATA;
                end else begin
                    state_d = rden_q ? DATA : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        dqs_en_d = rden_d || wren_d;
    end

    always_ff @(posedge clk_i) begin
        if (reset0_i) begin
            state_q    <= IDLE;
            bc_q       <= 3'd0;
            gap_q      <= NB_GAP;
            dl_q       <= '0;
            cnt_q      <= 8'd0;
            busy_cnt_q <= 5'd0;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
            err_q      <= 1'b0;
            rden_q     <= 1'b0;
            wren_q     <= 1'b0;
            dqs_en_q   <= 1'b0;
            dqs_rst_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bc_q       <= bc_d;
            gap_q      <= gap_d;
            dl_q       <= dl_d;
            cnt_q      <= cnt_d;
            busy_cnt_q <= busy_cnt_d;
            busy_q     <= busy_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
            rden_q     <= rden_d;
            wren_q     <= wren_d;
            dqs_en_q   <= dqs_en_d;
            dqs_rst_q  <= dqs_rst_d;
        end
    end

    assign wdf_rden_o       = rden_q;
    assign ctrl_wren_o      = wren_q;
    assign ctrl_dqs_rst_o   = dqs_rst_q;
    assign ctrl_dqs_en_o    = dqs_en_q;
    assign wr_busy_o        = busy_q;
    assign wr_overlap_err_o = err_q;
    assign burst_cnt_o      = cnt_q;

endmodule

// File: tb/tb_ddr2_wr_burst_sequencer_0.sv
// Bench for ddr2_wr_burst_sequencer_0: per-cycle waveform masks for two configurations plus a
// burst counter wrap sequence.
module tb_ddr2_wr_burst_sequencer_0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, cmd_a, rst_b, cmd_b;
    logic       rden_a, wren_a, dqsr_a, dqsen_a, busy_a, err_a;
    logic       rden_b, wren_b, dqsr_b, dqsen_b, busy_b, err_b;
    logic [7:0] cnt_a, cnt_b;

    ddr2_wr_burst_sequencer_0 #(.WR_LAT(3), .BURST_LEN(4)) dut_a (
        .clk_i(clk), .reset0_i(rst_a), .wr_cmd_i(cmd_a),
        .wdf_rden_o(rden_a), .ctrl_wren_o(wren_a), .ctrl_dqs_rst_o(dqsr_a),
        .ctrl_dqs_en_o(dqsen_a), .wr_busy_o(busy_a), .wr_overlap_err_o(err_a),
        .burst_cnt_o(cnt_a)
    );

    ddr2_wr_burst_sequencer_0 #(.WR_LAT(5), .BURST_LEN(8)) dut_b (
        .clk_i(clk), .reset0_i(rst_b), .wr_cmd_i(cmd_b),
        .wdf_rden_o(rden_b), .ctrl_wren_o(wren_b), .ctrl_dqs_rst_o(dqsr_b),
        .ctrl_dqs_en_o(dqsen_b), .wr_busy_o(busy_b), .wr_overlap_err_o(err_b),
        .burst_cnt_o(cnt_b)
    );

    // Bit c of each mask is the value during cycle c (cycle c follows the edge sampling cmd c)
    typedef struct {
        int          dut;
        logic [31:0] cmd;
        logic [31:0] rsti;
        logic [31:0] rden;
        logic [31:0] wren;
        logic [31:0] en;
        logic [31:0] dqsr;
        logic [31:0] busy;
        logic [31:0] err;
        logic [7:0]  cnt;
        string       name;
    } vec_t;

    localparam int NCYC = 25;
    vec_t vecs[7];
    int   checks = 0;
    int   passed = 0;

    function automatic logic [31:0] rng(input int lo, input int hi);
        logic [31:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] bt(input int c);
        logic [31:0] m = '0;
        m[c] = 1'b1;
        return m;
    endfunction

    function automatic logic [7:0] sample(input int dut);
        if (dut == 0) return {2'b00, rden_a, wren_a, dqsen_a, dqsr_a, busy_a, err_a};
        return {2'b00, rden_b, wren_b, dqsen_b, dqsr_b, busy_b, err_b};
    endfunction

    task automatic check(input string name, input int cyc, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s cyc %0d got %b expected %b", name, cyc, got, exp);
    endtask

    task automatic drive(input int dut, input logic rst, input logic cmd);
        rst_a = (dut == 0) ? rst : 1'b0;
        cmd_a = (dut == 0) ? cmd : 1'b0;
        rst_b = (dut == 1) ? rst : 1'b0;
        cmd_b = (dut == 1) ? cmd : 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1; cmd_a = 1'b0; cmd_b = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] exp;
        do_reset();
        for (int c = 0; c < NCYC; c++) begin
            drive(v.dut, v.rsti[c], v.cmd[c]);
            @(posedge clk);
            #1;
            exp = {2'b00, v.rden[c], v.wren[c], v.en[c], v.dqsr[c], v.busy[c], v.err[c]};
            check({v.name, " rden/wren/en/rst/busy/err"}, c, sample(v.dut), exp);
            @(negedge clk);
        end
        check({v.name, " burst_cnt"}, NCYC - 1, (v.dut == 0) ? cnt_a : cnt_b, v.cnt);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; cmd_a = 1'b0; cmd_b = 1'b0;

        vecs[0] = '{0, bt(10), 32'd0, rng(12,13), rng(13,14), rng(12,14), bt(12),
                    rng(10,14), 32'd0, 8'd1, "single"};
        vecs[1] = '{0, bt(10) | bt(12), 32'd0, rng(12,15), rng(13,16), rng(12,16), bt(12),
                    rng(10,16), 32'd0, 8'd2, "back_to_back"};
        vecs[2] = '{0, bt(10) | bt(11), 32'd0, rng(12,13), rng(13,14), rng(12,14), bt(12),
                    rng(10,14), rng(12,24), 8'd1, "overlap_drop"};
        vecs[3] = '{0, bt(10) | bt(13), 32'd0, rng(12,13) | rng(15,16),
                    rng(13,14) | rng(16,17), rng(12,17), bt(12), rng(10,17), 32'd0, 8'd2,
                    "gap_nb_plus1"};
        vecs[4] = '{0, bt(10) | bt(14), 32'd0, rng(12,13) | rng(16,17),
                    rng(13,14) | rng(17,18), rng(12,14) | rng(16,18), bt(12) | bt(16),
                    rng(10,18), 32'd0, 8'd2, "gap_nb_plus2"};
        vecs[5] = '{1, bt(0), bt(7), rng(4,6), rng(5,6), rng(4,6), bt(4),
                    rng(0,6), 32'd0, 8'd0, "bl8_reset_mid_burst"};
        vecs[6] = '{0, bt(10), bt(11), 32'd0, 32'd0, 32'd0, 32'd0,
                    bt(10), 32'd0, 8'd0, "reset_in_delay_line"};

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // 256 legal commands spaced by NB: counter wraps to zero, no error
        do_reset();
        for (int k = 0; k < 512; k++) begin
            drive(0, 1'b0, (k % 2) == 0);
            @(posedge clk);
            #1;
            if (k == 508) check("wrap burst_cnt before wrap", k, cnt_a, 8'd255);
            if (k == 510) check("wrap burst_cnt after wrap", k, cnt_a, 8'd0);
            @(negedge clk);
        end
        drive(0, 1'b0, 1'b0);
        check("wrap overlap_err", 512, {7'd0, err_a}, 8'd0);
        repeat (8) @(negedge clk);
        check("wrap idle after last burst", 520, sample(0), 8'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
